lcd_frame_ctrl: RTL and testbench

- Frame-level sequencer and configurator for the RGB LCD timing generator.
- Runs panel power-up: panel reset pulse, settle wait, blanked frames, then a backlight ramp.
- Owns the backlight PWM and counts display frames from the generator's data-request stream.
- Arbitrates page-switch requests from the vending-machine UI so a page change only takes effect on a frame boundary. This keeps tearing off the panel.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_bl_pwm.sv | 24 ++
 rtl/lcd_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_lcd_frame_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants for the LCD frame controller: FSM encoding, bus widths and
// the backlight ramp helper.
package lcd_pkg;

   localparam int unsigned PAGE_W = 3;
   localparam int unsigned RGB_W  = 24;

   localparam logic [2:0] S_PANEL_RST = 3'd0;
   localparam logic [2:0] S_PWR_WAIT  = 3'd1;
   localparam logic [2:0] S_BLANK     = 3'd2;
   localparam logic [2:0] S_RAMP      = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;

   // One ramp step: min(level + step, target), summed in 9 bits so the add cannot wrap.
   function automatic logic [7:0] ramp_next(input logic [7:0] level,
                                            input logic [7:0] step,
                                            input logic [7:0] target);
      logic [8:0] sum;
      sum = {1'b0, level} + {1'b0, step};
      if (sum > {1'b0, target}) begin
         ramp_next = target;
      end else begin
         ramp_next = sum[7:0];
      end
   endfunction

endpackage

// File: rtl/lcd_bl_pwm.sv
// Backlight PWM: 8-bit free-running counter compared against the level.
// Level 8'hFF means fully on; the output is registered and gated by en.
module lcd_bl_pwm (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] level,
   output logic       pwm
);

   logic [7:0] cnt;

   // Counter runs in every state; the enable only gates the registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 8'd0;
         pwm <= 1'b0;
      end else begin
         cnt <= cnt + 8'd1;
         pwm <= en & ((cnt < level) | (level == 8'hFF));
      end
   end

endmodule

// File: rtl/lcd_frame_ctrl.sv
// Frame-level sequencer for the RGB LCD timing generator: panel power-up,
// blanking, backlight ramp, frame counting and tear-free page switching.
module lcd_frame_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned RST_CYC      = 1000,
   parameter int unsigned PWR_WAIT     = 100000,
   parameter int unsigned BLANK_FRAMES = 2,
   parameter int unsigned RAMP_STEP    = 8,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic              lcd_pclk,
   input  logic              rst,
   input  logic              data_req,
   input  logic [10:0]       v_disp,
   input  logic [RGB_W-1:0]  pixel_in,
   output logic [RGB_W-1:0]  pixel_out,
   input  logic              page_req,
   input  logic [PAGE_W-1:0] page_id_in,
   output logic              page_ack,
   output logic [PAGE_W-1:0] page_cur,
   input  logic [7:0]        bl_duty,
   output logic              lcd_bl,
   output logic              lcd_rst,
   output logic              frame_end,
   output logic [15:0]       frame_cnt,
   output logic              blink,
   output logic              ready
);

   localparam int unsigned WAIT_MAX = (RST_CYC > PWR_WAIT) ? RST_CYC : PWR_WAIT;
   localparam int unsigned CYC_W    = $clog2(WAIT_MAX + 1);
   localparam int unsigned BLK_W    = $clog2(BLANK_FRAMES + 1);
   localparam int unsigned BLN_W    = $clog2(BLINK_FRAMES + 1);

   logic              req_d;
   logic [10:0]       line_cnt;
   logic              fall;
   logic              last_line;
   logic [BLN_W-1:0]  blink_cnt;
   logic [2:0]        state, state_d;
   logic [CYC_W-1:0]  cyc_cnt, cyc_d;
   logic [BLK_W-1:0]  blank_cnt, blank_d;
   logic [7:0]        bl_level, level_d;
   logic              pending;
   logic [PAGE_W-1:0] pend_id;
   logic              req_hold;
   logic              lit;

   assign fall      = req_d & ~data_req;
   assign last_line = (v_disp != 11'd0) && (line_cnt == v_disp - 11'd1);

   // Line counting on falling edges of data_req; frame_end follows the last line by one cycle.
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         req_d     <= 1'b0;
         line_cnt  <= 11'd0;
         frame_end <= 1'b0;
      end else begin
         req_d     <= data_req;
         frame_end <= fall & last_line;
         if (fall) begin
            line_cnt <= last_line ? 11'd0 : line_cnt + 11'd1;
         end
      end
   end

   // Frame counter and blink divider, both advanced by frame_end.
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         frame_cnt <= 16'd0;
         blink     <= 1'b0;
         blink_cnt <= '0;
      end else if (frame_end) begin
         frame_cnt <= frame_cnt + 16'd1;
         if (blink_cnt == BLN_W'(BLINK_FRAMES - 1)) begin
            blink     <= ~blink;
            blink_cnt <= '0;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Power-up sequencing and backlight level next-state.
   always_comb begin
      state_d = state;
      cyc_d   = cyc_cnt;
      blank_d = blank_cnt;
      level_d = bl_level;
      case (state)
         S_PANEL_RST: begin
            if (cyc_cnt == CYC_W'(RST_CYC - 1)) begin
               state_d = S_PWR_WAIT;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_cnt + 1'b1;
            end
         end
         S_PWR_WAIT: begin
            if (cyc_cnt == CYC_W'(PWR_WAIT - 1)) begin
               state_d = S_BLANK;
               cyc_d   = '0;
               blank_d = '0;
            end else begin
               cyc_d = cyc_cnt + 1'b1;
            end
         end
         S_BLANK: begin
            // A frame already under way on entry still ends with a frame_end and counts.
            if (frame_end) begin
               if (blank_cnt == BLK_W'(BLANK_FRAMES - 1)) begin
                  state_d = S_RAMP;
               end else begin
                  blank_d = blank_cnt + 1'b1;
               end
            end
         end
         S_RAMP: begin
            if (frame_end) begin
               level_d = ramp_next(bl_level, 8'(RAMP_STEP), bl_duty);
               if (level_d == bl_duty) begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (frame_end) begin
               level_d = bl_duty;
            end
         end
         default: begin
            state_d = S_PANEL_RST;
         end
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         state     <= S_PANEL_RST;
         cyc_cnt   <= '0;
         blank_cnt <= '0;
         bl_level  <= 8'd0;
      end else begin
         state     <= state_d;
         cyc_cnt   <= cyc_d;
         blank_cnt <= blank_d;
         bl_level  <= level_d;
      end
   end

   // Page handshake: latch one request, commit it on a frame boundary, then
   // wait for page_req to drop before accepting another.
   always_ff @(posedge lcd_pclk) begin
      if (rst) begin
         pending  <= 1'b0;
         pend_id  <= '0;
         page_cur <= '0;
         page_ack <= 1'b0;
         req_hold <= 1'b0;
      end else begin
         page_ack <= frame_end & pending;
         if (frame_end & pending) begin
            page_cur <= pend_id;
            pending  <= 1'b0;
            req_hold <= 1'b1;
         end else begin
            if (page_req & ~pending & ~req_hold) begin
               pending <= 1'b1;
               pend_id <= page_id_in;
            end
            if (~page_req) begin
               req_hold <= 1'b0;
            end
         end
      end
   end

   assign lit       = (state == S_RAMP) || (state == S_RUN);
   assign pixel_out = lit ? pixel_in : '0;
   assign lcd_rst   = (state != S_PANEL_RST);
   assign ready     = (state == S_RUN);

   lcd_bl_pwm u_bl_pwm (
      .clk   (lcd_pclk),
      .rst   (rst),
      .en    (lit),
      .level (bl_level),
      .pwm   (lcd_bl)
   );

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl: behavioural model compared every
// cycle, plus literal checks on the power-up, ramp and page sequences.
module tb_lcd_frame_ctrl;

   localparam int unsigned RST_CYC      = 4;
   localparam int unsigned PWR_WAIT     = 8;
   localparam int unsigned BLANK_FRAMES = 2;
   localparam int unsigned RAMP_STEP    = 8;
   localparam int unsigned BLINK_FRAMES = 3;

   logic        clk;
   logic        rst;
   logic        data_req;
   logic [10:0] v_disp;
   logic [23:0] pixel_in;
   logic [23:0] pixel_out;
   logic        page_req;
   logic [2:0]  page_id_in;
   logic        page_ack;
   logic [2:0]  page_cur;
   logic [7:0]  bl_duty;
   logic        lcd_bl;
   logic        lcd_rst;
   logic        frame_end;
   logic [15:0] frame_cnt;
   logic        blink;
   logic        ready;

   int tests = 0;
   int fails = 0;
   int ack_total = 0;
   bit ui_rand = 0;
   bit rand_pix = 0;

   lcd_frame_ctrl #(
      .RST_CYC      (RST_CYC),
      .PWR_WAIT     (PWR_WAIT),
      .BLANK_FRAMES (BLANK_FRAMES),
      .RAMP_STEP    (RAMP_STEP),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .lcd_pclk   (clk),
      .rst        (rst),
      .data_req   (data_req),
      .v_disp     (v_disp),
      .pixel_in   (pixel_in),
      .pixel_out  (pixel_out),
      .page_req   (page_req),
      .page_id_in (page_id_in),
      .page_ack   (page_ack),
      .page_cur   (page_cur),
      .bl_duty    (bl_duty),
      .lcd_bl     (lcd_bl),
      .lcd_rst    (lcd_rst),
      .frame_end  (frame_end),
      .frame_cnt  (frame_cnt),
      .blink      (blink),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phase: 0 panel reset, 1 power wait, 2 blank, 3 ramp, 4 run.
   int m_phase, m_cyc, m_lines, m_blank, m_lvl, m_frames, m_pid, m_cur;
   bit m_fe, m_prev_req, m_pend, m_hold, m_ack, m_bl, m_valid;

   always @(posedge clk) begin : model
      bit fe;
      int ph, lvl, pwmc;
      if (rst) begin
         m_phase = 0; m_cyc = 0; m_lines = 0; m_blank = 0; m_lvl = 0; m_frames = 0;
         m_pid = 0; m_cur = 0; m_fe = 0; m_prev_req = 0; m_pend = 0; m_hold = 0;
         m_ack = 0; m_bl = 0; m_valid = 1;
      end else begin
         fe   = m_fe;
         ph   = m_phase;
         lvl  = m_lvl;
         pwmc = m_cyc % 256;
         m_bl = (ph >= 3) && ((pwmc < lvl) || (lvl == 255));
         m_fe = 0;
         if (m_prev_req && !data_req) begin
            m_lines++;
            if (v_disp != 0 && m_lines == int'(v_disp)) begin
               m_lines = 0;
               m_fe = 1;
            end
         end
         m_prev_req = data_req;
         if (fe) m_frames++;
         m_cyc++;
         case (ph)
            0: if (m_cyc >= RST_CYC) m_phase = 1;
            1: if (m_cyc >= RST_CYC + PWR_WAIT) begin m_phase = 2; m_blank = 0; end
            2: if (fe) begin
                  m_blank++;
                  if (m_blank == BLANK_FRAMES) m_phase = 3;
               end
            3: if (fe) begin
                  m_lvl = (lvl + RAMP_STEP > int'(bl_duty)) ? int'(bl_duty) : lvl + RAMP_STEP;
                  if (m_lvl == int'(bl_duty)) m_phase = 4;
               end
            default: if (fe) m_lvl = int'(bl_duty);
         endcase
         m_ack = 0;
         if (fe && m_pend) begin
            m_cur = m_pid; m_pend = 0; m_ack = 1; m_hold = 1;
         end else begin
            if (page_req && !m_pend && !m_hold) begin
               m_pend = 1;
               m_pid = int'(page_id_in);
            end
            if (!page_req) m_hold = 0;
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (page_ack === 1'b1) ack_total++;
      if (m_valid) begin
         chk("lcd_rst", 32'(lcd_rst), 32'(m_phase != 0));
         chk("ready", 32'(ready), 32'(m_phase == 4));
         chk("pixel_out", 32'(pixel_out), (m_phase >= 3) ? 32'(pixel_in) : 32'd0);
         chk("lcd_bl", 32'(lcd_bl), 32'(m_bl));
         chk("frame_end", 32'(frame_end), 32'(m_fe));
         chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
         chk("blink", 32'(blink), 32'((m_frames / BLINK_FRAMES) % 2));
         chk("page_cur", 32'(page_cur), 32'(m_cur));
         chk("page_ack", 32'(page_ack), 32'(m_ack));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (rand_pix) pixel_in = 24'($urandom);
      if (ui_rand) begin
         if (page_req && page_ack) begin
            page_req = 1'b0;
         end else if (!page_req && $urandom_range(0, 11) == 0) begin
            page_req   = 1'b1;
            page_id_in = 3'($urandom);
         end
      end
   endtask

   task automatic line(input int n, input int g);
      data_req = 1'b1;
      repeat (n) step();
      data_req = 1'b0;
      repeat (g) step();
   endtask

   // Sends nlines lines; the last one ends in frame_end when v_disp lines are complete.
   task automatic frame(input int nlines, input bit fe_req, input logic [2:0] id,
                        input bit chk_fe);
      for (int i = 0; i < nlines - 1; i++) line($urandom_range(1, 5), $urandom_range(2, 4));
      data_req = 1'b1;
      repeat ($urandom_range(1, 5)) step();
      data_req = 1'b0;
      step();
      if (chk_fe) chk("frame_end_timing", 32'(frame_end), 32'd1);
      if (fe_req) begin
         page_req   = 1'b1;
         page_id_in = id;
      end
      repeat (2) step();
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int a0;
      int hi;
      rst = 1'b1; data_req = 1'b0; v_disp = 11'd3; pixel_in = 24'hFFFFFF;
      page_req = 1'b0; page_id_in = 3'd0; bl_duty = 8'd20;
      repeat (3) step();
      rst = 1'b0;
      chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("reset_page_cur", 32'(page_cur), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("lcd_rst_low", 32'(lcd_rst), 32'd0);
         step();
      end
      chk("lcd_rst_high", 32'(lcd_rst), 32'd1);
      repeat (8) step();
      chk("blank_pixel", 32'(pixel_out), 32'd0);

      // Blank frames, then ramp 8 -> 16 -> 20.
      frame(3, 0, 3'd0, 1);
      chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
      chk("still_blank", 32'(pixel_out), 32'd0);
      frame(3, 0, 3'd0, 1);
      chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
      chk("ramp_pixel", 32'(pixel_out), 32'hFFFFFF);
      rand_pix = 1'b1;
      frame(3, 0, 3'd0, 1);
      chk("blink_after_3", 32'(blink), 32'd1);
      frame(3, 0, 3'd0, 1);
      chk("ready_ramp", 32'(ready), 32'd0);
      frame(3, 0, 3'd0, 1);
      chk("ready_run", 32'(ready), 32'd1);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         if (lcd_bl) hi++;
         step();
      end
      chk("pwm_duty_20", 32'(hi), 32'd20);

      // Page request mid-frame; second id during pending is ignored.
      a0 = ack_total;
      line(3, 2);
      page_req = 1'b1; page_id_in = 3'd5;
      step();
      chk("page_hold_0", 32'(page_cur), 32'd0);
      page_id_in = 3'd3;
      step();
      frame(2, 0, 3'd0, 1);
      chk("page_commit_5", 32'(page_cur), 32'd5);
      chk("single_ack", 32'(ack_total - a0), 32'd1);
      frame(3, 0, 3'd0, 1);
      chk("no_relatch", 32'(page_cur), 32'd5);
      chk("no_second_ack", 32'(ack_total - a0), 32'd1);
      page_req = 1'b0;
      step();

      // Request rising in the frame_end cycle waits for the next frame.
      frame(3, 1, 3'd6, 1);
      chk("deferred", 32'(page_cur), 32'd5);
      frame(3, 0, 3'd0, 1);
      chk("deferred_commit", 32'(page_cur), 32'd6);
      page_req = 1'b0;
      step();

      // v_disp == 0 never produces frame_end.
      a0 = int'(frame_cnt);
      v_disp = 11'd0;
      frame(3, 0, 3'd0, 0);
      frame(3, 0, 3'd0, 0);
      chk("vdisp0_no_frames", 32'(frame_cnt), 32'(a0));

      // Reset in S_RUN with a pending request.
      line(2, 2);
      page_req = 1'b1; page_id_in = 3'd2;
      step();
      rst = 1'b1;
      step();
      chk("rst_lcd_rst", 32'(lcd_rst), 32'd0);
      chk("rst_lcd_bl", 32'(lcd_bl), 32'd0);
      chk("rst_page_cur", 32'(page_cur), 32'd0);
      chk("rst_page_ack", 32'(page_ack), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      rst = 1'b0; page_req = 1'b0; v_disp = 11'd3; bl_duty = 8'd0;

      // Second power-up with zero duty: run after the first ramp frame.
      repeat (RST_CYC + PWR_WAIT + 2) step();
      frame(3, 0, 3'd0, 1);
      frame(3, 0, 3'd0, 1);
      frame(3, 0, 3'd0, 1);
      chk("duty0_ready", 32'(ready), 32'd1);
      chk("pending_dropped", 32'(page_cur), 32'd0);

      // Randomised run: UI requests, duty changes including full-on.
      ui_rand = 1'b1;
      bl_duty = 8'hFF;
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0: bl_duty = 8'h00;
               1: bl_duty = 8'hFF;
               default: bl_duty = 8'($urandom);
            endcase
         end
         frame(3, 0, 3'd0, 1);
         repeat ($urandom_range(0, 20)) step();
      end
      ui_rand = 1'b0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
